unified_mem_arbiter: RTL and testbench

//  Shares the single-port unified memory between the instruction-fetch requester (F) and the

---
 rtl/dsd_mem_pkg.sv | 14 +
 rtl/arb_starve_counter.sv | 37 +++
 rtl/unified_mem_arbiter.sv | 96 +++++++++
 tb/tb_unified_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dsd_mem_pkg.sv
// Shared types and default sizing for the unified-memory arbiter slice.
package dsd_mem_pkg;

  localparam int unsigned DEF_AW         = 16;
  localparam int unsigned DEF_DW         = 16;
  localparam int unsigned DEF_MAX_DBURST = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RET_F = 2'd1,
    RET_D = 2'd2
  } rd_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive contested D wins; limit_o forces the next F grant.
module arb_starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc_i,
  input  logic                       clr_i,
  output logic [$clog2(MAX+1)-1:0]   cnt_o,
  output logic                       limit_o
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign limit_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch (F) and load/store (D) onto the single-port unified memory;
// D has priority, read data returns registered one cycle after grant.
module unified_mem_arbiter
  import dsd_mem_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MAX_DBURST = DEF_MAX_DBURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  rd_state_t     rd_state_q, rd_state_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          starve_limit;
  logic [$clog2(MAX_DBURST+1)-1:0] starve_cnt;

  arb_starve_counter #(
    .MAX (MAX_DBURST)
  ) u_starve (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (d_gnt & f_req),
    .clr_i   (f_gnt | ~f_req),
    .cnt_o   (starve_cnt),
    .limit_o (starve_limit)
  );

  // Grants are qualified by reset so the memory bus stays quiet while held in reset.
  always_comb begin
    f_gnt      = 1'b0;
    d_gnt      = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    rd_state_d = IDLE;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (reset) begin
      if (f_req && (!d_req || starve_limit)) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
    if (f_gnt) begin
      mem_addr   = f_addr;
      rd_state_d = RET_F;
      f_rdata_d  = mem_rd;
    end else if (d_gnt) begin
      mem_addr = d_addr;
      mem_we   = d_we;
      mem_wd   = d_wdata;
      if (!d_we) begin
        rd_state_d = RET_D;
        d_rdata_d  = mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= IDLE;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_rvalid = (rd_state_q == RET_F);
  assign d_rvalid = (rd_state_q == RET_D);
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed scenarios plus randomized
// requesters checked against a behavioural arbitration/memory model.
module tb_unified_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_gnt, f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DBURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's own copy.
  bit [DW-1:0] tb_mem  [0:65535];
  bit [DW-1:0] ref_mem [0:65535];
  assign mem_rd = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit rst; bit fg; bit dg; bit we; bit [AW-1:0] addr; bit [DW-1:0] wd; } gexp_t;
  typedef struct { int cyc; bit isf; bit [DW-1:0] data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int errors = 0;
  int checks = 0;
  int wins   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, compute expected behaviour from the rules, enqueue it.
  task automatic drive(input bit rstn, input bit fr, input logic [AW-1:0] fa,
                       input bit dr, input bit dwe, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd, output bit fg, output bit dg);
    gexp_t e;
    @(posedge clk); #1;
    reset = rstn; f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    e = '{cyc: cyc, rst: !rstn, fg: 0, dg: 0, we: 0, addr: '0, wd: '0};
    fg = 0; dg = 0;
    if (!rstn) begin
      wins = 0;
      rq.delete();
    end else begin
      if (fr && dr) begin
        if (wins == MAXB) fg = 1; else dg = 1;
      end else if (fr) fg = 1;
      else if (dr) dg = 1;
      if (fg || !fr) wins = 0;
      else if (dg) wins++;
      e.fg = fg; e.dg = dg;
      if (fg) begin
        e.addr = fa;
        rq.push_back('{cyc: cyc, isf: 1, data: ref_mem[fa]});
      end else if (dg) begin
        e.addr = da; e.we = dwe; e.wd = dwd;
        if (dwe) ref_mem[da] = dwd;
        else rq.push_back('{cyc: cyc, isf: 0, data: ref_mem[da]});
      end
    end
    gq.push_back(e);
  endtask

  // Monitor: compares bus-side grants every cycle and read returns when due.
  always @(negedge clk) begin
    gexp_t e;
    rexp_t r;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      e = gq.pop_front();
      chk("f_gnt", f_gnt, e.fg);
      chk("d_gnt", d_gnt, e.dg);
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_we", mem_we, e.we);
      chk("mem_wd", mem_wd, e.wd);
      chk("gnt_exclusive", f_gnt & d_gnt, 0);
      if (e.rst) begin
        chk("rst_rdata", {f_rdata, d_rdata}, 0);
      end
    end
    if (rq.size() > 0 && rq[0].cyc + 1 == cyc) begin
      r = rq.pop_front();
      chk("f_rvalid", f_rvalid, r.isf);
      chk("d_rvalid", d_rvalid, !r.isf);
      if (r.isf) chk("f_rdata", f_rdata, r.data);
      else       chk("d_rdata", d_rdata, r.data);
    end else begin
      chk("no_rvalid", {f_rvalid, d_rvalid}, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit fg, dg;
    bit fp, dp, dwe_r;
    logic [AW-1:0] fa, da;
    logic [DW-1:0] dwd;
    int k;

    for (int i = 0; i < 65536; i++) begin
      bit [DW-1:0] v;
      v = DW'($urandom);
      tb_mem[i] = v;
      ref_mem[i] = v;
    end
    tb_mem[16'h0010]  = 16'hA5A5;
    ref_mem[16'h0010] = 16'hA5A5;

    drive(0, 1, 16'h0010, 1, 0, 16'h0001, 0, fg, dg);
    drive(0, 0, 0, 0, 0, 0, 0, fg, dg);

    // 1: F alone
    drive(1, 1, 16'h0010, 0, 0, 0, 0, fg, dg);
    drive(1, 0, 0, 0, 0, 0, 0, fg, dg);

    // 2: sustained contention, D loads advance only on D grants
    fa = 16'h0010; k = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, fa, 1, 0, AW'(16'h0030 + k), 0, fg, dg);
      if (fg) fa = fa + 1;
      if (dg) k++;
    end
    drive(1, 0, 0, 0, 0, 0, 0, fg, dg);

    // 3: store then load of the same word
    drive(1, 0, 0, 1, 1, 16'h0020, 16'h1234, fg, dg);
    drive(1, 0, 0, 1, 0, 16'h0020, 0, fg, dg);
    drive(1, 0, 0, 0, 0, 0, 0, fg, dg);

    // 4: back-to-back interleave F, D, F
    drive(1, 1, 16'h0000, 0, 0, 0, 0, fg, dg);
    drive(1, 0, 0, 1, 0, 16'h0040, 0, fg, dg);
    drive(1, 1, 16'h0001, 0, 0, 0, 0, fg, dg);
    drive(1, 0, 0, 0, 0, 0, 0, fg, dg);

    // 5: reset the cycle after an F grant, then repeat test 1
    drive(1, 1, 16'h0010, 0, 0, 0, 0, fg, dg);
    drive(0, 0, 0, 0, 0, 0, 0, fg, dg);
    drive(1, 1, 16'h0010, 0, 0, 0, 0, fg, dg);
    drive(1, 0, 0, 0, 0, 0, 0, fg, dg);

    // 6: F withdraws after 3 D wins, then needs 4 fresh contested losses
    for (int i = 0; i < 3; i++) drive(1, 1, 16'h0050, 1, 0, AW'(16'h0060 + i), 0, fg, dg);
    drive(1, 0, 0, 1, 0, 16'h0063, 0, fg, dg);
    for (int i = 0; i < 6 && !fg; i++) drive(1, 1, 16'h0050, 1, 0, AW'(16'h0064 + i), 0, fg, dg);
    drive(1, 0, 0, 0, 0, 0, 0, fg, dg);

    // Randomized requesters sharing a small address window so loads see stores.
    fp = 0; dp = 0; fa = 0; da = 0; dwd = 0; dwe_r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit fr;
      if ($urandom_range(0, 399) == 0) begin
        drive(0, 0, 0, 0, 0, 0, 0, fg, dg);
        fp = 0; dp = 0;
        continue;
      end
      if (!fp && $urandom_range(0, 3) != 0) begin fp = 1; fa = AW'($urandom_range(0, 63)); end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; da = AW'($urandom_range(0, 63)); dwe_r = 1'($urandom); dwd = DW'($urandom);
      end
      fr = fp;
      if (fp && $urandom_range(0, 19) == 0) begin fp = 0; fr = 0; end
      drive(1, fr, fr ? fa : AW'($urandom), dp, dwe_r, da, dwd, fg, dg);
      if (fg) fp = 0;
      if (dg) dp = 0;
    end

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, fg, dg);
    @(negedge clk); #1;
    chk("drain_rq", rq.size(), 0);
    chk("drain_gq", gq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
